// File: rtl/usb2_ep_sched.sv
// Bulk IN transaction scheduler: decodes IN/OUT tokens, answers DATA/NAK/STALL,
// grants an endpoint read port, arms the buffer on host ACK and tracks per-endpoint halt.
module usb2_ep_sched #(
    parameter int NUM_EP  = 4,
    parameter int EP_BASE = 1,
    parameter int ARM_TO  = 64,
    localparam int IW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic                   phy_clk,
    input  logic                   reset_n,
    input  logic                   tok_valid,
    input  logic [3:0]             tok_ep,
    input  logic                   tok_in,
    output logic                   tok_ready,
    output logic                   resp_valid,
    output logic [1:0]             resp_code,
    output logic                   xfer_active,
    output logic [IW-1:0]          xfer_idx,
    output logic [9:0]             xfer_len,
    output logic [1:0]             xfer_toggle,
    input  logic                   xfer_done,
    input  logic                   xfer_acked,
    input  logic [NUM_EP-1:0]      ep_hasdata,
    input  logic [10*NUM_EP-1:0]   ep_len,
    input  logic [2*NUM_EP-1:0]    ep_toggle,
    output logic [NUM_EP-1:0]      ep_arm,
    input  logic [NUM_EP-1:0]      ep_arm_ack,
    output logic [NUM_EP-1:0]      ep_toggle_act,
    input  logic                   halt_set,
    input  logic                   halt_clr,
    input  logic [3:0]             halt_ep,
    output logic [NUM_EP-1:0]      ep_halted,
    output logic                   arm_err
);
    localparam int CW = $clog2(ARM_TO + 1);
    localparam logic [1:0] RC_DATA  = 2'b00;
    localparam logic [1:0] RC_NAK   = 2'b01;
    localparam logic [1:0] RC_STALL = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_RESP, S_XFER, S_ARM, S_ARM_REL} state_t;
    state_t state, state_nxt;

    logic [3:0]        tok_ep_q;
    logic              tok_in_q;
    logic [1:0]        code_q;
    logic [CW-1:0]     arm_cnt;
    logic              rel_low;
    logic [NUM_EP-1:0] halted, halted_nxt;

    logic [3:0]        dec_off, halt_off;
    logic              dec_hit, halt_hit;
    logic [IW-1:0]     dec_idx;
    logic [1:0]        dec_code;

    assign ep_halted = halted;

    always_comb begin
        dec_off = tok_ep_q - 4'(EP_BASE);
        dec_hit = (tok_ep_q >= 4'(EP_BASE)) && (32'(dec_off) < NUM_EP);
        dec_idx = dec_off[IW-1:0];
        if (!dec_hit || !tok_in_q)  dec_code = RC_STALL;
        else if (halted[dec_idx])   dec_code = RC_STALL;
        else if (!ep_hasdata[dec_idx]) dec_code = RC_NAK;
        else                        dec_code = RC_DATA;
    end

    // Set beats clear when both target the same endpoint in one cycle.
    always_comb begin
        halt_off   = halt_ep - 4'(EP_BASE);
        halt_hit   = (halt_ep >= 4'(EP_BASE)) && (32'(halt_off) < NUM_EP);
        halted_nxt = halted;
        for (int i = 0; i < NUM_EP; i++) begin
            if (halt_hit && (32'(halt_off) == i)) begin
                if (halt_set)      halted_nxt[i] = 1'b1;
                else if (halt_clr) halted_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge phy_clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tok_ep_q    <= '0;
            tok_in_q    <= 1'b0;
            code_q      <= '0;
            xfer_idx    <= '0;
            xfer_len    <= '0;
            xfer_toggle <= '0;
            arm_cnt     <= '0;
            rel_low     <= 1'b0;
            halted      <= '0;
        end else begin
            state  <= state_nxt;
            halted <= halted_nxt;
            if (state == S_IDLE && tok_valid) begin
                tok_ep_q <= tok_ep;
                tok_in_q <= tok_in;
            end
            if (state == S_DECODE) begin
                code_q <= dec_code;
                if (dec_code == RC_DATA) begin
                    xfer_idx    <= dec_idx;
                    xfer_len    <= ep_len[10*dec_idx +: 10];
                    xfer_toggle <= ep_toggle[2*dec_idx +: 2];
                end
            end
            arm_cnt <= (state == S_ARM) ? arm_cnt + CW'(1) : '0;
            // Tracks one low ack cycle already seen while releasing.
            rel_low <= (state == S_ARM_REL) && !ep_arm_ack[xfer_idx];
        end
    end

    always_comb begin
        state_nxt     = state;
        tok_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_code     = 2'b00;
        xfer_active   = 1'b0;
        ep_arm        = '0;
        ep_toggle_act = '0;
        arm_err       = 1'b0;
        case (state)
            S_IDLE: begin
                tok_ready = 1'b1;
                if (tok_valid) state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                resp_code  = code_q;
                if (code_q == RC_DATA) begin
                    xfer_active = 1'b1;
                    state_nxt   = S_XFER;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_XFER: begin
                xfer_active = 1'b1;
                if (xfer_done) state_nxt = xfer_acked ? S_ARM : S_IDLE;
            end
            S_ARM: begin
                ep_arm[xfer_idx] = 1'b1;
                if (ep_arm_ack[xfer_idx]) begin
                    ep_toggle_act[xfer_idx] = 1'b1;
                    state_nxt = S_ARM_REL;
                end else if (arm_cnt == CW'(ARM_TO - 1)) begin
                    arm_err   = 1'b1;
                    state_nxt = S_ARM_REL;
                end
            end
            S_ARM_REL: begin
                if (!ep_arm_ack[xfer_idx] && rel_low) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_usb2_ep_sched.sv
// Scoreboard bench for usb2_ep_sched: random tokens/halts against a table-level
// endpoint model; a negedge monitor checks every response and counts arm/toggle activity.
module tb_usb2_ep_sched;
    localparam int NUM_EP = 4, EP_BASE = 1, ARM_TO = 64, IW = 2;

    logic phy_clk = 1'b0, reset_n = 1'b0;
    logic tok_valid = 1'b0, tok_in = 1'b0, tok_ready;
    logic [3:0] tok_ep = '0;
    logic resp_valid, xfer_active, arm_err;
    logic [1:0] resp_code, xfer_toggle;
    logic [IW-1:0] xfer_idx;
    logic [9:0] xfer_len;
    logic xfer_done = 1'b0, xfer_acked = 1'b0;
    logic [NUM_EP-1:0] ep_hasdata = '0, ep_arm, ep_arm_ack = '0, ep_toggle_act, ep_halted;
    logic [10*NUM_EP-1:0] ep_len = '0;
    logic [2*NUM_EP-1:0] ep_toggle = '0;
    logic halt_set = 1'b0, halt_clr = 1'b0;
    logic [3:0] halt_ep = '0;

    usb2_ep_sched #(.NUM_EP(NUM_EP), .EP_BASE(EP_BASE), .ARM_TO(ARM_TO)) dut (
        .phy_clk(phy_clk), .reset_n(reset_n), .tok_valid(tok_valid), .tok_ep(tok_ep),
        .tok_in(tok_in), .tok_ready(tok_ready), .resp_valid(resp_valid), .resp_code(resp_code),
        .xfer_active(xfer_active), .xfer_idx(xfer_idx), .xfer_len(xfer_len),
        .xfer_toggle(xfer_toggle), .xfer_done(xfer_done), .xfer_acked(xfer_acked),
        .ep_hasdata(ep_hasdata), .ep_len(ep_len), .ep_toggle(ep_toggle), .ep_arm(ep_arm),
        .ep_arm_ack(ep_arm_ack), .ep_toggle_act(ep_toggle_act), .halt_set(halt_set),
        .halt_clr(halt_clr), .halt_ep(halt_ep), .ep_halted(ep_halted), .arm_err(arm_err));

    always #5 phy_clk = ~phy_clk;

    typedef struct { int code; int idx; int len; int tog; int cyc; } exp_t;
    exp_t sbq[$];
    int total = 0, bad = 0, cyc = 0;
    int tog_cnt[NUM_EP], arm_cyc[NUM_EP];
    int tog_tot = 0, err_cnt = 0;

    // Endpoint-side model: buffer contents, lengths, toggles, halts by USB endpoint number.
    bit has[NUM_EP];
    int len_a[NUM_EP], tog_a[NUM_EP];
    bit hlt[16];

    always @(posedge phy_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic apply_env();
        for (int i = 0; i < NUM_EP; i++) begin
            ep_hasdata[i]       = has[i];
            ep_len[10*i +: 10]  = 10'(len_a[i]);
            ep_toggle[2*i +: 2] = 2'(tog_a[i]);
        end
    endtask

    function automatic int model_code(input int ep, input bit in);
        if (!in || ep < EP_BASE || ep >= EP_BASE + NUM_EP) return 2;
        if (hlt[ep]) return 2;
        if (!has[ep - EP_BASE]) return 1;
        return 0;
    endfunction

    function automatic int hvec();
        int r = 0;
        for (int i = 0; i < NUM_EP; i++) if (hlt[EP_BASE + i]) r |= (1 << i);
        return r;
    endfunction

    function automatic int sum_arm();
        int s = 0;
        for (int i = 0; i < NUM_EP; i++) s += arm_cyc[i];
        return s;
    endfunction

    always @(negedge phy_clk) begin
        exp_t e;
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("resp_code", int'(resp_code), e.code);
                chk("resp_cycle", cyc, e.cyc);
                if (e.code == 0) begin
                    chk("resp_xfer_active", int'(xfer_active), 1);
                    chk("xfer_idx", int'(xfer_idx), e.idx);
                    chk("xfer_len", int'(xfer_len), e.len);
                    chk("xfer_toggle", int'(xfer_toggle), e.tog);
                end
            end
        end
        for (int i = 0; i < NUM_EP; i++) begin
            if (ep_toggle_act[i]) tog_cnt[i]++;
            if (ep_arm[i]) arm_cyc[i]++;
        end
        tog_tot += $countones(ep_toggle_act);
        if (arm_err) err_cnt++;
        if ($countones(ep_arm) > 1 || $countones(ep_toggle_act) > 1)
            chk("onehot_arm_toggle", 0, 1);
    end

    task automatic halt_op(input bit s, input bit c, input int ep);
        halt_set = s; halt_clr = c; halt_ep = 4'(ep);
        tick();
        halt_set = 1'b0; halt_clr = 1'b0;
        if (ep >= EP_BASE && ep < EP_BASE + NUM_EP) begin
            if (s) hlt[ep] = 1'b1;
            else if (c) hlt[ep] = 1'b0;
        end
        chk("ep_halted", int'(ep_halted), hvec());
    endtask

    task automatic txn(input int ep, input bit in, input bit acked, input bit tmo,
                       input int d, input int h, input bit spur, input bit rst_arm);
        exp_t e;
        int w, idx, sa, st, se, si, ai;
        w = 0;
        while (!tok_ready && w < 200) begin tick(); w++; end
        chk("tok_ready_wait", int'(tok_ready), 1);
        idx = ep - EP_BASE;
        e.code = model_code(ep, in); e.idx = 0; e.len = 0; e.tog = 0; e.cyc = cyc + 2;
        if (e.code == 0) begin e.idx = idx; e.len = len_a[idx]; e.tog = tog_a[idx]; end
        sbq.push_back(e);
        tok_valid = 1'b1; tok_ep = 4'(ep); tok_in = in;
        tick();
        tok_valid = 1'b0; tok_in = 1'b0;
        tick(); tick();
        if (e.code != 0) begin
            chk("no_xfer_after_nak_stall", int'(xfer_active), 0);
            chk("idle_after_resp", int'(tok_ready), 1);
            return;
        end
        sa = sum_arm(); st = tog_tot; se = err_cnt; si = tog_cnt[idx]; ai = arm_cyc[idx];
        repeat ($urandom_range(0, 3)) tick();
        if (spur) begin
            tok_valid = 1'b1; tok_ep = 4'(ep); tok_in = 1'b1;
            tick();
            tok_valid = 1'b0; tok_in = 1'b0;
        end
        chk("xfer_active", int'(xfer_active), 1);
        xfer_done = 1'b1; xfer_acked = acked;
        tick();
        xfer_done = 1'b0; xfer_acked = 1'b0;
        if (!acked) begin
            tick(); tick();
            chk("nack_no_arm", sum_arm() - sa, 0);
            chk("nack_no_toggle", tog_tot - st, 0);
            chk("nack_idle", int'(tok_ready), 1);
            return;
        end
        w = 0;
        while (!ep_arm[idx] && w < 8) begin tick(); w++; end
        chk("arm_raise", int'(ep_arm[idx]), 1);
        if (rst_arm) begin
            reset_n = 1'b0;
            tick();
            chk("rst_arm_drop", int'(ep_arm), 0);
            chk("rst_tok_ready", int'(tok_ready), 1);
            chk("rst_halts_clear", int'(ep_halted), 0);
            reset_n = 1'b1;
            for (int i = 0; i < 16; i++) hlt[i] = 1'b0;
            return;
        end
        if (tmo) begin
            w = 0;
            while (ep_arm[idx] && w < ARM_TO + 20) begin tick(); w++; end
            w = 0;
            while (!tok_ready && w < 10) begin tick(); w++; end
            chk("tmo_idle", int'(tok_ready), 1);
            chk("tmo_arm_err", err_cnt - se, 1);
            chk("tmo_arm_len_ok", int'((arm_cyc[idx] - ai) inside {ARM_TO, ARM_TO + 1}), 1);
            chk("tmo_no_toggle", tog_tot - st, 0);
        end else begin
            repeat (d) tick();
            ep_arm_ack[idx] = 1'b1;
            repeat (h) tick();
            ep_arm_ack[idx] = 1'b0;
            w = 0;
            while (!tok_ready && w < 10) begin tick(); w++; end
            chk("rel_wait_cycles", w, 2);
            chk("toggle_pulse", tog_cnt[idx] - si, 1);
            chk("toggle_total", tog_tot - st, 1);
            chk("arm_cycles", sum_arm() - sa, d + 1);
            chk("no_arm_err", err_cnt - se, 0);
            has[idx] = 1'b0;
            tog_a[idx] ^= 1;
            apply_env();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        tick(); tick();
        chk("reset_tok_ready", int'(tok_ready), 1);
        chk("reset_resp_valid", int'(resp_valid), 0);
        chk("reset_xfer_active", int'(xfer_active), 0);
        chk("reset_ep_arm", int'(ep_arm), 0);
        chk("reset_halted", int'(ep_halted), 0);
        chk("reset_arm_err", int'(arm_err), 0);
        reset_n = 1'b1;
        tick();

        has[0] = 1'b1; len_a[0] = 64; apply_env();
        txn(1, 1, 1, 0, 2, 2, 0, 0);
        txn(2, 1, 1, 0, 0, 1, 0, 0);
        txn(0, 1, 1, 0, 0, 1, 0, 0);
        txn(5, 1, 1, 0, 0, 1, 0, 0);
        has[0] = 1'b1; apply_env();
        txn(1, 0, 1, 0, 0, 1, 0, 0);

        has[2] = 1'b1; len_a[2] = 100; apply_env();
        halt_op(1, 0, 3);
        txn(3, 1, 1, 0, 0, 1, 0, 0);
        halt_op(1, 1, 3);
        txn(3, 1, 1, 0, 0, 1, 0, 0);
        halt_op(0, 1, 3);
        txn(3, 1, 1, 0, 1, 3, 1, 0);

        has[3] = 1'b1; len_a[3] = 7; tog_a[3] = 1; apply_env();
        txn(4, 1, 0, 0, 0, 1, 0, 0);
        txn(4, 1, 1, 0, 1, 1, 0, 0);

        has[0] = 1'b1; len_a[0] = 12; apply_env();
        txn(1, 1, 1, 1, 0, 1, 0, 0);

        halt_op(1, 0, 2);
        has[1] = 1'b1; len_a[1] = 33; apply_env();
        halt_op(0, 0, 3);
        txn(2, 1, 1, 0, 0, 1, 0, 0);
        has[1] = 1'b1; apply_env();
        halt_op(1, 0, 4);
        txn(2, 1, 1, 0, 0, 1, 0, 1);
        tick();

        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < NUM_EP; i++)
                if (!has[i] && $urandom_range(0, 2) == 0) begin
                    has[i] = 1'b1; len_a[i] = $urandom_range(0, 512);
                end
            apply_env();
            if ($urandom_range(0, 7) == 0)
                halt_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
            else
                txn($urandom_range(0, 6), $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 4), $urandom_range(1, 3),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
        end

        repeat (4) tick();
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
